// File: rtl/rotator_multiply.sv
// rotator_multiply: twiddle rotation stage of a streaming FFT layer.
// Four-stage pipeline with capture, products, sums, and round/saturate.
// Samples with select=0 bypass the math but keep the same latency.
// Data registers load every cycle. Only the valid bits and the output/status
// registers are reset, so a reset drops every sample still in flight.
module rotator_multiply #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 18,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_re,
    input  logic [DATA_W-1:0] din_im,
    input  logic              select,
    input  logic [TW_W-1:0]   tw_re,
    input  logic [TW_W-1:0]   tw_im,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout_re,
    output logic [DATA_W-1:0] dout_im,
    output logic              sat_flag,
    output logic [15:0]       sat_count
);

    localparam int MW   = DATA_W + TW_W;      // product width
    localparam int PW   = DATA_W + TW_W + 1;  // sum width, holds ac-bd without wrap
    localparam int FRAC = TW_W - 2;           // twiddle fraction bits

    localparam logic signed [PW-1:0] ROUND_C = PW'(1) <<< (FRAC - 1);
    localparam logic signed [PW-1:0] MAX_P   = (PW'(1) <<< (DATA_W - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MIN_P   = -(PW'(1) <<< (DATA_W - 1));
    localparam logic [DATA_W-1:0]    MAX_D   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]    MIN_D   = {1'b1, {(DATA_W-1){1'b0}}};

    // Stage valid bits: vld_pipe[k] qualifies stage k+1 registers.
    logic [LAT-2:0] vld_pipe;

    // S1 registers
    logic signed [DATA_W-1:0] re1, im1;
    logic signed [TW_W-1:0]   twr1, twi1;
    logic                     sel1;

    // S2 registers
    logic signed [MW-1:0]     ac2, bd2, ad2, bc2;
    logic signed [DATA_W-1:0] re2, im2;
    logic                     sel2;

    // S3 registers
    logic signed [PW-1:0]     pre3, pim3;
    logic signed [DATA_W-1:0] re3, im3;
    logic                     sel3;

    // S4 combinational rounding and clipping
    logic signed [PW-1:0]     rnd_re, rnd_im;
    logic                     sat_re, sat_im;
    logic [DATA_W-1:0]        res_re, res_im;
    logic                     sat_any;

    // Valid shift register; reset drops every in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-3:0], din_valid};
        end
    end

    // S1: capture sample, twiddle and select as they arrive together.
    always_ff @(posedge clk) begin
        re1  <= $signed(din_re);
        im1  <= $signed(din_im);
        twr1 <= $signed(tw_re);
        twi1 <= $signed(tw_im);
        sel1 <= select;
    end

    // S2: the four partial products, sign-extended to full product width.
    always_ff @(posedge clk) begin
        ac2  <= MW'(re1) * MW'(twr1);
        bd2  <= MW'(im1) * MW'(twi1);
        ad2  <= MW'(re1) * MW'(twi1);
        bc2  <= MW'(im1) * MW'(twr1);
        re2  <= re1;
        im2  <= im1;
        sel2 <= sel1;
    end

    // S3: complex sums with one guard bit so no wrap is possible.
    always_ff @(posedge clk) begin
        pre3 <= PW'(ac2) - PW'(bd2);
        pim3 <= PW'(ad2) + PW'(bc2);
        re3  <= re2;
        im3  <= im2;
        sel3 <= sel2;
    end

    // Round half up, drop the fraction, then clip each component to DATA_W.
    always_comb begin
        rnd_re = (pre3 + ROUND_C) >>> FRAC;
        rnd_im = (pim3 + ROUND_C) >>> FRAC;
        sat_re = 1'b0;
        sat_im = 1'b0;
        res_re = rnd_re[DATA_W-1:0];
        res_im = rnd_im[DATA_W-1:0];
        if (rnd_re > MAX_P) begin
            res_re = MAX_D;
            sat_re = 1'b1;
        end else if (rnd_re < MIN_P) begin
            res_re = MIN_D;
            sat_re = 1'b1;
        end
        if (rnd_im > MAX_P) begin
            res_im = MAX_D;
            sat_im = 1'b1;
        end else if (rnd_im < MIN_P) begin
            res_im = MIN_D;
            sat_im = 1'b1;
        end
        sat_any = sel3 && (sat_re || sat_im);
    end

    // S4: output register; holds its last value when no sample arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
        end else begin
            dout_valid <= vld_pipe[LAT-2];
            if (vld_pipe[LAT-2]) begin
                dout_re <= sel3 ? res_re : re3;
                dout_im <= sel3 ? res_im : im3;
            end
        end
    end

    // Saturation status: sticky flag and a per-sample counter that holds at max.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (vld_pipe[LAT-2] && sat_any) begin
            sat_flag <= 1'b1;
            if (sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule
